// File: rtl/pll_reconfig.sv
// MMCM dynamic reconfiguration controller. It rewrites the CLKFBOUT and CLKOUTn
// counters through the DRP, sequences the MMCM reset and filters the raw LOCKED.
module pll_reconfig #(
    parameter int NUM_OUTPUTS        = 4,
    parameter int RST_HOLD_CYCLES    = 8,
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int LOCK_TIMEOUT       = 65535
) (
    input  logic                     refclk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [6:0]               cfg_mult,
    input  logic [8*NUM_OUTPUTS-1:0] cfg_divide,
    output logic [6:0]               drp_addr,
    output logic [15:0]              drp_di,
    input  logic [15:0]              drp_do,
    output logic                     drp_den,
    output logic                     drp_dwe,
    input  logic                     drp_drdy,
    output logic                     mmcm_rst,
    input  logic                     mmcm_locked,
    output logic                     locked,
    output logic                     busy,
    output logic                     cfg_error
);
    localparam int NUM_OPS     = 2 * (NUM_OUTPUTS + 1);
    localparam int OP_W        = $clog2(NUM_OPS);
    localparam int DRP_TIMEOUT = 255;
    localparam int TMR_MAX     = (LOCK_TIMEOUT > RST_HOLD_CYCLES) ? LOCK_TIMEOUT : RST_HOLD_CYCLES;
    localparam int TMR_W       = $clog2((TMR_MAX > 256) ? TMR_MAX : 256);
    localparam int LCK_W       = $clog2(LOCK_STABLE_CYCLES + 1);

    typedef enum logic [2:0] {
        RESET_HOLD, WAIT_LOCK, IDLE, READ, WAIT_READ, WRITE, WAIT_WRITE, ERROR
    } state_t;

    state_t                   state, next_state;
    logic [TMR_W-1:0]         tmr;
    logic [OP_W-1:0]          op;
    logic [2:0]               chan;
    logic [6:0]               mult_q;
    logic [8*NUM_OUTPUTS-1:0] div_q;
    logic [15:0]              wr_q;
    logic                     mmcm_rst_q;
    logic                     cfg_error_q;
    logic                     cfg_legal;
    logic                     xfer;
    logic [7:0]               d_val;
    logic [5:0]               hi_enc, lo_enc;
    logic [15:0]              wr_data;
    logic [LCK_W-1:0]         lock_cnt, lock_cnt_next;
    logic                     lock_next;
    logic                     unused_drp_bits;

    // Channel 0 is CLKFBOUT; channel n+1 is CLKOUTn. REG2 sits at base + 1.
    function automatic logic [6:0] reg1_addr(input logic [2:0] ch);
        case (ch)
            3'd0:    return 7'h14;
            3'd1:    return 7'h08;
            3'd2:    return 7'h0A;
            3'd3:    return 7'h0C;
            3'd4:    return 7'h0E;
            3'd5:    return 7'h10;
            3'd6:    return 7'h06;
            default: return 7'h12;
        endcase
    endfunction

    assign xfer            = cfg_valid && (state == IDLE);
    assign chan            = 3'(op >> 1);
    assign unused_drp_bits = ^drp_do[7:6];

    always_comb begin
        cfg_legal = (cfg_mult >= 7'd2) && (cfg_mult <= 7'd64);
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (cfg_divide[8*i +: 8] == 8'd0 || cfg_divide[8*i +: 8] > 8'd128)
                cfg_legal = 1'b0;
        end
    end

    always_comb begin
        d_val = {1'b0, mult_q};
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (chan == 3'(i + 1))
                d_val = div_q[8*i +: 8];
        end
    end

    // A count of 64 wraps to 0 in the 6-bit fields, which the MMCM reads as 64.
    assign hi_enc  = d_val[6:1];
    assign lo_enc  = 6'(d_val - {1'b0, d_val[7:1]});
    assign wr_data = op[0] ? {drp_do[15:8], d_val[0], (d_val == 8'd1), drp_do[5:0]}
                           : {drp_do[15:12], hi_enc, lo_enc};

    // Lock filter: consecutive-high counter, cleared by a low sample or MMCM reset.
    always_comb begin
        if (mmcm_rst_q || !mmcm_locked)
            lock_cnt_next = '0;
        else if (lock_cnt != LCK_W'(LOCK_STABLE_CYCLES))
            lock_cnt_next = lock_cnt + 1'b1;
        else
            lock_cnt_next = lock_cnt;
    end
    assign lock_next = (lock_cnt_next == LCK_W'(LOCK_STABLE_CYCLES));

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) state <= RESET_HOLD;
        else     state <= next_state;
    end

    // NOTE: always_comb assigns every output a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            RESET_HOLD: if (tmr == TMR_W'(RST_HOLD_CYCLES - 1)) next_state = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_next)                              next_state = IDLE;
                else if (tmr == TMR_W'(LOCK_TIMEOUT - 1))   next_state = ERROR;
            end
            IDLE:       if (xfer && cfg_legal) next_state = READ;
            READ:       next_state = WAIT_READ;
            WAIT_READ: begin
                if (drp_drdy)                               next_state = WRITE;
                else if (tmr == TMR_W'(DRP_TIMEOUT - 1))    next_state = ERROR;
            end
            WRITE:      next_state = WAIT_WRITE;
            WAIT_WRITE: begin
                if (drp_drdy)
                    next_state = (op == OP_W'(NUM_OPS - 1)) ? RESET_HOLD : READ;
                else if (tmr == TMR_W'(DRP_TIMEOUT - 1))
                    next_state = ERROR;
            end
            ERROR:      next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            tmr         <= '0;
            op          <= '0;
            mult_q      <= '0;
            div_q       <= '0;
            wr_q        <= '0;
            mmcm_rst_q  <= 1'b1;
            cfg_error_q <= 1'b0;
            lock_cnt    <= '0;
        end else begin
            lock_cnt <= lock_cnt_next;
            tmr      <= (state != next_state) ? '0 : tmr + 1'b1;
            case (state)
                IDLE: if (xfer) begin
                    mult_q      <= cfg_mult;
                    div_q       <= cfg_divide;
                    op          <= '0;
                    cfg_error_q <= !cfg_legal;
                    mmcm_rst_q  <= cfg_legal;
                end
                WAIT_READ:  if (drp_drdy) wr_q <= wr_data;
                WAIT_WRITE: if (drp_drdy) op <= op + 1'b1;
                RESET_HOLD: if (next_state == WAIT_LOCK) mmcm_rst_q <= 1'b0;
                default: ;
            endcase
            if (next_state == ERROR) begin
                mmcm_rst_q  <= 1'b0;
                cfg_error_q <= 1'b1;
            end
        end
    end

    assign cfg_ready = (state == IDLE);
    assign drp_den   = (state == READ) || (state == WRITE);
    assign drp_dwe   = (state == WRITE);
    assign drp_addr  = drp_den ? (reg1_addr(chan) | {6'd0, op[0]}) : 7'd0;
    assign drp_di    = drp_dwe ? wr_q : 16'd0;
    assign busy      = !((state == IDLE) || (state == ERROR));
    assign mmcm_rst  = mmcm_rst_q;
    assign cfg_error = cfg_error_q;
    assign locked    = (lock_cnt == LCK_W'(LOCK_STABLE_CYCLES)) && mmcm_locked && !mmcm_rst_q;

endmodule

// File: doc/pll_reconfig.md
PLL_RECONFIG -- requirements
Module: pll_reconfig

Interface
REQ-001 SHALL have parameter NUM_OUTPUTS, default 4, number of programmed MMCM CLKOUTn channels (1-7).
REQ-002 SHALL have parameter RST_HOLD_CYCLES, default 8, number of refclk cycles mmcm_rst is held high per sequence.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 16, number of consecutive mmcm_locked-high cycles before locked is reported.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 65535, maximum refclk cycles to wait for lock.
REQ-005 SHALL have ports, in order:
refclk  in  1  sole clock (also the DRP clock)
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  new configuration offered
cfg_ready  out  1  configuration accepted this cycle when cfg_valid=1
cfg_mult  in  7  CLKFBOUT multiply, legal 2-64
cfg_divide  in  8*NUM_OUTPUTS  CLKOUTn divide, channel n in bits [8n+7:8n], legal 1-128
drp_addr  out  7  DRP address
drp_di  out  16  DRP write data
drp_do  in  16  DRP read data
drp_den  out  1  DRP enable, one-cycle pulse
drp_dwe  out  1  DRP write enable, high with drp_den for writes only
drp_drdy  in  1  DRP access complete
mmcm_rst  out  1  MMCM reset
mmcm_locked  in  1  raw MMCM LOCKED
locked  out  1  filtered lock
busy  out  1  sequence in progress
cfg_error  out  1  last request rejected or timed out

Function
REQ-006 SHALL implement states RESET_HOLD, WAIT_LOCK, IDLE, READ, WAIT_READ, WRITE, WAIT_WRITE, ERROR.
REQ-007 cfg_ready SHALL be 1 only in IDLE; a transfer occurs when cfg_valid and cfg_ready are both 1 on a rising refclk edge.
REQ-008 On transfer, cfg_mult and cfg_divide SHALL be registered; if any value is outside its legal range, the block SHALL set cfg_error=1, perform no DRP access, leave mmcm_rst low, and remain in IDLE.
REQ-009 On a legal transfer, the block SHALL clear cfg_error, assert mmcm_rst and busy on the next cycle, and enter READ.
REQ-010 Register sequence SHALL be CLKFBOUT (0x14, 0x15), then CLKOUT0..CLKOUT(NUM_OUTPUTS-1): CLKOUT0 0x08/0x09, 1 0x0A/0x0B, 2 0x0C/0x0D, 3 0x0E/0x0F, 4 0x10/0x11, 5 0x06/0x07, 6 0x12/0x13; each channel writes REG1 then REG2, for 2*(NUM_OUTPUTS+1) read-modify-write operations.
REQ-011 Each operation SHALL use a read (drp_den=1, drp_dwe=0, one cycle), wait for drp_drdy, then a write (drp_den=1, drp_dwe=1, one cycle), then wait for drp_drdy; at most one DRP access SHALL be outstanding.
REQ-012 For value D: high = floor(D/2), low = D - high, edge = D mod 2, no_count = (D==1).
REQ-013 REG1 write data SHALL be {drp_do[15:12], high[5:0], low[5:0]}; REG2 write data SHALL be {drp_do[15:8], edge, no_count, drp_do[5:0]}.
REQ-014 For D=64, high=32 and low=32, encoded as 6'd32; for D=128, high=low=64, encoded as 6'd0 (MMCM convention).
REQ-015 If drp_drdy does not arrive within 255 cycles of drp_den, the block SHALL enter ERROR.
REQ-016 After the last write completes, the block SHALL enter RESET_HOLD, keep mmcm_rst=1 for RST_HOLD_CYCLES more cycles, deassert it, and enter WAIT_LOCK.
REQ-017 WAIT_LOCK SHALL go to IDLE, deasserting busy, once locked=1; if LOCK_TIMEOUT cycles elapse first, it SHALL enter ERROR.
REQ-018 ERROR SHALL set cfg_error=1 and deassert mmcm_rst, busy, drp_den and drp_dwe, then go to IDLE on the next cycle.
REQ-019 Lock filter: a saturating counter SHALL count consecutive mmcm_locked=1 cycles; locked=1 SHALL assert when the count reaches LOCK_STABLE_CYCLES.
REQ-020 The lock filter counter and locked SHALL clear in the same cycle mmcm_locked=0 is sampled, or while mmcm_rst=1.
REQ-021 A lock loss in IDLE SHALL only drop locked; it SHALL NOT start a sequence.
REQ-022 cfg_valid SHALL be ignored outside IDLE, and inputs SHALL NOT be re-sampled mid-sequence.

Reset
REQ-023 While rst=1, outputs SHALL be: mmcm_rst=1, busy=1, cfg_ready=0, locked=0, cfg_error=0, drp_den=0, drp_dwe=0, drp_addr=0, drp_di=0.
REQ-024 After rst falls, the block SHALL enter RESET_HOLD, then follow the REQ-016/REQ-017 path with no DRP access.
REQ-025 rst asserted mid-sequence SHALL abort immediately to the REQ-023 values; any DRP response arriving after reset SHALL be ignored.

Verification
REQ-026 Power-up: release rst with MMCM model locking 100 cycles after mmcm_rst falls -> mmcm_rst low after 8 cycles; locked=1 and busy=0 16 cycles after model lock.
REQ-027 Reprogram, NUM_OUTPUTS=4: mult=3, divides 4/6/9/18, drp_do=16'hF000 for all reads -> 10 writes; 0x14 gets 16'hF042, 0x15 gets 16'hF080, 0x08 gets 16'hF082, 0x0E gets 16'hF249; mmcm_rst high during all writes.
REQ-028 Illegal request: mult=1 -> cfg_error=1, no drp_den, mmcm_rst stays 0, cfg_ready=1 the next cycle.
REQ-029 DRP hang: drp_drdy never returned -> ERROR after 255 cycles; cfg_error=1, mmcm_rst=0, IDLE on the next cycle.
REQ-030 Lock glitch: mmcm_locked low for 1 cycle in IDLE -> locked drops in the same cycle and re-asserts 16 cycles after mmcm_locked returns high; no DRP activity.
REQ-031 Reset mid-write, plus D=1 and D=128 encoding: rst asserted during WAIT_WRITE -> REQ-023 values; a late drp_drdy is ignored; D=1 -> REG2 bit 6 = 1; D=128 -> REG1[11:0] = 0.
